// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style bus receiver: command codes,
// character constants, controller states and the command classifier.
package lcd_pkg;

  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam logic [7:0] LINE2_BASE  = 8'h40;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPLAY = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  typedef enum logic {
    IDLE,
    CLEAR
  } lcd_state_t;

  typedef enum logic [2:0] {
    K_NOP,
    K_CLEAR,
    K_HOME,
    K_ENTRY,
    K_DISPLAY,
    K_DDRAM
  } cmd_kind_t;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } bus_word_t;

  // The highest set bit selects the instruction; range compares express that directly.
  function automatic cmd_kind_t cmd_kind(input logic [7:0] code);
    if (code >= CMD_DDRAM)        return K_DDRAM;
    else if (code >= CMD_SHIFT)   return K_NOP;
    else if (code >= CMD_DISPLAY) return K_DISPLAY;
    else if (code >= CMD_ENTRY)   return K_ENTRY;
    else if (code >= CMD_HOME)    return K_HOME;
    else if (code == CMD_CLEAR)   return K_CLEAR;
    else                          return K_NOP;
  endfunction

endpackage

// File: rtl/lcd_bus_receiver_if.sv
// Parallel LCD write bus as driven by an external LCD writer.
interface lcd_bus_receiver_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  modport master (output LCD_E, LCD_RS, LCD_RW, LCD_DATA);
  modport slave  (input  LCD_E, LCD_RS, LCD_RW, LCD_DATA);
endinterface

// File: rtl/lcd_edge_sync.sv
// Synchronizes the asynchronous LCD bus and flags falling edges of the enable strobe.
module lcd_edge_sync
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      bus_e,
  input  bus_word_t bus_word,
  output logic      e,
  output bus_word_t word,
  output logic      fall
);

  logic [SYNC_STAGES-1:0] e_chain;
  logic [SYNC_STAGES-1:0] valid_chain;
  bus_word_t              word_chain [SYNC_STAGES];
  logic                   e_prev;
  logic                   armed;

  // valid_chain marks when e_chain holds only post-reset samples; a fall only
  // counts once E has been seen low, so E held high across reset never strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_chain     <= '0;
      valid_chain <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) word_chain[i] <= '0;
      e_prev      <= 1'b0;
      armed       <= 1'b0;
    end else begin
      e_chain     <= {e_chain[SYNC_STAGES-2:0], bus_e};
      valid_chain <= {valid_chain[SYNC_STAGES-2:0], 1'b1};
      word_chain[0] <= bus_word;
      for (int i = 1; i < SYNC_STAGES; i++) word_chain[i] <= word_chain[i-1];
      e_prev      <= e_chain[SYNC_STAGES-1];
      if (valid_chain[SYNC_STAGES-1] && !e_chain[SYNC_STAGES-1]) armed <= 1'b1;
    end
  end

  assign e    = e_chain[SYNC_STAGES-1];
  assign word = word_chain[SYNC_STAGES-1];
  assign fall = armed & e_prev & ~e;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Shadows a two-line character display by snooping HD44780 write cycles:
// keeps a 2*LINE_LEN character buffer, cursor, entry direction and display-on bit.
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LINE_LEN    = 16
) (
  input  logic               clk,
  input  logic               rst,
  lcd_bus_receiver_if.slave  bus,
  input  logic [4:0]         rd_addr,
  output logic [7:0]         rd_char,
  output logic [4:0]         cursor,
  output logic               disp_on,
  output logic               busy,
  output logic               cmd_valid,
  output logic [7:0]         cmd_code,
  output logic               err
);

  localparam int         DEPTH    = 2 * LINE_LEN;
  localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);
  localparam logic [6:0] L1_END   = 7'(LINE_LEN);
  localparam logic [6:0] L2_BASE  = LINE2_BASE[6:0];
  localparam logic [6:0] L2_END   = 7'(int'(LINE2_BASE) + LINE_LEN);

  bus_word_t  raw_word;
  bus_word_t  sync_word;
  logic       sync_e;
  logic       strobe;

  bus_word_t  held;
  lcd_state_t state;
  logic [4:0] clr_idx;
  logic       id;
  logic [7:0] buffer [DEPTH];

  logic [4:0] next_cursor;
  logic [6:0] addr;
  logic       ddram_ok;
  logic [4:0] ddram_idx;

  assign raw_word = '{rs: bus.LCD_RS, rw: bus.LCD_RW, data: bus.LCD_DATA};

  lcd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .bus_e    (bus.LCD_E),
    .bus_word (raw_word),
    .e        (sync_e),
    .word     (sync_word),
    .fall     (strobe)
  );

  assign addr = held.data[6:0];

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    next_cursor = cursor;
    ddram_ok    = 1'b0;
    ddram_idx   = cursor;
    if (id) next_cursor = (cursor == LAST_IDX) ? 5'd0 : cursor + 5'd1;
    else    next_cursor = (cursor == 5'd0) ? LAST_IDX : cursor - 5'd1;
    if (addr < L1_END) begin
      ddram_ok  = 1'b1;
      ddram_idx = addr[4:0];
    end else if (addr >= L2_BASE && addr < L2_END) begin
      ddram_ok  = 1'b1;
      ddram_idx = 5'(addr - L2_BASE + L1_END);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the buffer has a defined reset image (all spaces), so it is
      // cleared cell by cell here rather than left uninitialised like plain RAM.
      for (int i = 0; i < DEPTH; i++) buffer[i] <= CHAR_SPACE;
      state     <= IDLE;
      clr_idx   <= '0;
      cursor    <= '0;
      id        <= 1'b1;
      disp_on   <= 1'b0;
      busy      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      err       <= 1'b0;
      rd_char   <= CHAR_SPACE;
      held      <= '0;
    end else begin
      cmd_valid <= 1'b0;
      rd_char   <= buffer[rd_addr];
      if (sync_e) held <= sync_word;

      if (state == CLEAR) begin
        buffer[clr_idx] <= CHAR_SPACE;
        if (clr_idx == LAST_IDX) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          clr_idx <= clr_idx + 5'd1;
        end
      end

      // Read cycles are invisible; anything else during a clear is a protocol error.
      if (strobe && !held.rw) begin
        if (busy) begin
          err <= 1'b1;
        end else if (held.rs) begin
          buffer[cursor] <= held.data;
          cursor         <= next_cursor;
        end else begin
          cmd_valid <= 1'b1;
          cmd_code  <= held.data;
          unique case (cmd_kind(held.data))
            K_CLEAR: begin
              state   <= CLEAR;
              busy    <= 1'b1;
              clr_idx <= '0;
              cursor  <= '0;
              id      <= 1'b1;
            end
            K_HOME:    cursor  <= '0;
            K_ENTRY:   id      <= held.data[1];
            K_DISPLAY: disp_on <= held.data[2];
            K_DDRAM: begin
              if (ddram_ok) cursor <= ddram_idx;
              else          err    <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed and randomized bench for lcd_bus_receiver against a behavioural display model.
module tb_lcd_bus_receiver;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [4:0] cursor;
  logic       disp_on;
  logic       busy;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       err;

  lcd_bus_receiver_if bus ();

  lcd_bus_receiver #(.SYNC_STAGES(2), .LINE_LEN(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rd_addr   (rd_addr),
    .rd_char   (rd_char),
    .cursor    (cursor),
    .disp_on   (disp_on),
    .busy      (busy),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .err       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always @(negedge clk) if (cmd_valid === 1'b1) pulses++;

  // Behavioural model of the display controller.
  logic [7:0] m_buf [32];
  int         m_cursor;
  bit         m_id;
  bit         m_disp;
  bit         m_err;
  logic [7:0] m_code;
  int         m_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    m_cursor = 0;
    m_id     = 1'b1;
    m_disp   = 1'b0;
    m_err    = 1'b0;
    m_code   = 8'h00;
  endtask

  task automatic model_apply(input bit rs, input bit rw, input logic [7:0] d);
    int v;
    if (rw) return;
    if (rs) begin
      m_buf[m_cursor] = d;
      m_cursor = m_id ? (m_cursor + 1) % 32 : (m_cursor + 31) % 32;
      return;
    end
    v = int'(d);
    m_pulses++;
    m_code = d;
    if (v == 1) begin
      for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
      m_cursor = 0;
      m_id     = 1'b1;
    end else if (v >= 2 && v <= 3)     m_cursor = 0;
    else if (v >= 4 && v <= 7)         m_id = (v / 2) % 2 == 1;
    else if (v >= 8 && v <= 15)        m_disp = (v / 4) % 2 == 1;
    else if (v >= 128 && v <= 143)     m_cursor = v - 128;
    else if (v >= 192 && v <= 207)     m_cursor = v - 192 + 16;
    else if (v >= 128)                 m_err = 1'b1;
  endtask

  task automatic op(input bit rs, input bit rw, input logic [7:0] d, input int gap);
    @(posedge clk); #1;
    bus.LCD_RS   = rs;
    bus.LCD_RW   = rw;
    bus.LCD_DATA = d;
    bus.LCD_E    = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.LCD_E = 1'b0;
    model_apply(rs, rw, d);
    repeat (gap) @(posedge clk);
  endtask

  task automatic read_cell(input int a, output logic [7:0] v);
    @(posedge clk); #1 rd_addr = 5'(a);
    @(posedge clk);
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.LCD_E = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, ".cursor"},   32'(cursor),   32'(m_cursor));
    check({tag, ".err"},      32'(err),      32'(m_err));
    check({tag, ".disp_on"},  32'(disp_on),  32'(m_disp));
    check({tag, ".cmd_code"}, 32'(cmd_code), 32'(m_code));
    check({tag, ".pulses"},   32'(pulses),   32'(m_pulses));
  endtask

  task automatic check_buffer(input string tag);
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      check($sformatf("%s.cell%0d", tag, i), 32'(v), 32'(m_buf[i]));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    int         p0;
    int         busy_cycles;
    bit         rs;
    bit         rw;
    logic [7:0] d;
    int         kind;

    rd_addr      = '0;
    rst          = 1'b1;
    bus.LCD_E    = 1'b0;
    bus.LCD_RS   = 1'b0;
    bus.LCD_RW   = 1'b0;
    bus.LCD_DATA = 8'h00;
    m_pulses     = 0;
    model_reset();

    // Reset state and blank buffer.
    do_reset();
    @(negedge clk);
    check("rst.rd_char",   32'(rd_char),   32'h20);
    check("rst.cursor",    32'(cursor),    32'd0);
    check("rst.err",       32'(err),       32'd0);
    check("rst.busy",      32'(busy),      32'd0);
    check("rst.cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst.cmd_code",  32'(cmd_code),  32'h00);
    check("rst.disp_on",   32'(disp_on),   32'd0);
    check_buffer("rst");

    // Enable held high across reset release must not produce a strobe on its fall.
    @(posedge clk); #1;
    bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_DATA = 8'h01; bus.LCD_E = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (6) @(posedge clk);
    #1 bus.LCD_E = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("e_across_rst.busy", 32'(busy), 32'd0);
    check_state("e_across_rst");

    // Line-2 address then two characters.
    p0 = pulses;
    op(1'b0, 1'b0, 8'h06, 6);
    op(1'b0, 1'b0, 8'hC0, 6);
    op(1'b1, 1'b0, 8'h41, 6);
    op(1'b1, 1'b0, 8'h42, 6);
    read_cell(16, v); check("line2.cell16", 32'(v), 32'h41);
    read_cell(17, v); check("line2.cell17", 32'(v), 32'h42);
    @(negedge clk);
    check("line2.cursor", 32'(cursor), 32'd18);
    check("line2.pulses", 32'(pulses - p0), 32'd2);

    // Decrement mode wraps 0 -> 31.
    op(1'b0, 1'b0, 8'h04, 6);
    op(1'b0, 1'b0, 8'h80, 6);
    op(1'b1, 1'b0, 8'h5A, 6);
    read_cell(0, v); check("dec.cell0", 32'(v), 32'h5A);
    @(negedge clk);
    check("dec.cursor", 32'(cursor), 32'd31);

    // Increment mode wraps 31 -> 0; line boundary 15 -> 16 is an ordinary step.
    op(1'b0, 1'b0, 8'h06, 6);
    op(1'b0, 1'b0, 8'hCF, 6);
    op(1'b1, 1'b0, 8'h61, 6);
    @(negedge clk);
    check("inc_wrap.cursor", 32'(cursor), 32'd0);
    op(1'b0, 1'b0, 8'h8F, 6);
    op(1'b1, 1'b0, 8'h62, 6);
    @(negedge clk);
    check("line_step.cursor", 32'(cursor), 32'd16);

    // Display control.
    op(1'b0, 1'b0, 8'h0C, 6);
    @(negedge clk); check("disp.on", 32'(disp_on), 32'd1);
    op(1'b0, 1'b0, 8'h0B, 6);
    @(negedge clk); check("disp.off", 32'(disp_on), 32'd0);

    // Read cycle is ignored entirely.
    p0 = pulses;
    op(1'b1, 1'b1, 8'h33, 6);
    @(negedge clk);
    check("rw.pulses", 32'(pulses - p0), 32'd0);
    check_state("rw");
    check_buffer("rw");

    // Illegal DDRAM address.
    p0 = pulses;
    op(1'b0, 1'b0, 8'h95, 6);
    @(negedge clk);
    check("illegal.err",      32'(err),          32'd1);
    check("illegal.cursor",   32'(cursor),       32'd16);
    check("illegal.cmd_code", 32'(cmd_code),     32'h95);
    check("illegal.pulses",   32'(pulses - p0),  32'd1);

    // Fill, clear, and a data strobe dropped while the clear runs.
    do_reset();
    for (int i = 0; i < 32; i++) op(1'b1, 1'b0, 8'($urandom_range(33, 126)), 4);
    check_buffer("fill");
    @(posedge clk); #1;
    bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_DATA = 8'h01; bus.LCD_E = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.LCD_E = 1'b0;
    model_apply(1'b0, 1'b0, 8'h01);
    busy_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin
        bus.LCD_RS = 1'b1; bus.LCD_DATA = 8'h55; bus.LCD_E = 1'b1;
      end
      if (i == 13) bus.LCD_E = 1'b0;
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
    end
    m_err = 1'b1;
    check("clear.busy_cycles", 32'(busy_cycles), 32'd32);
    check_state("clear");
    check_buffer("clear");

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 9));
      rw   = (kind == 0);
      rs   = (kind >= 1 && kind <= 4) || rw;
      if (rs) d = 8'($urandom_range(0, 255));
      else begin
        case ($urandom_range(0, 5))
          0: d = 8'h01;
          1: d = 8'($urandom_range(2, 15));
          2: d = 8'h80 | 8'($urandom_range(0, 15));
          3: d = 8'hC0 | 8'($urandom_range(0, 15));
          default: d = 8'($urandom_range(0, 255));
        endcase
      end
      op(rs, rw, d, (!rs && !rw && d == 8'h01) ? 42 : 6);
      check_state($sformatf("rand%0d", n));
    end
    check_buffer("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_bus_receiver.md
LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning input synchronizer depth (min 2).
REQ-002 SHALL have parameter LINE_LEN, default 16, meaning characters per display line (2 lines).
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port LCD_E  in  1  HD44780-style enable strobe from the LCD writer.
REQ-006 SHALL have port LCD_RS  in  1  1 = data, 0 = command.
REQ-007 SHALL have port LCD_RW  in  1  1 = read cycle, 0 = write cycle.
REQ-008 SHALL have port LCD_DATA  in  8  bus byte.
REQ-009 SHALL have port rd_addr  in  5  shadow-buffer index: 0-15 line 1, 16-31 line 2.
REQ-010 SHALL have port rd_char  out  8  character at rd_addr.
REQ-011 SHALL have port cursor  out  5  current write index.
REQ-012 SHALL have port disp_on  out  1  display-on bit from the last display-control command.
REQ-013 SHALL have port busy  out  1  high while a clear sequence runs.
REQ-014 SHALL have port cmd_valid  out  1  one-cycle pulse per accepted command.
REQ-015 SHALL have port cmd_code  out  8  byte of the last accepted command.
REQ-016 SHALL have port err  out  1  sticky: strobe while busy, or illegal DDRAM address.

Function
REQ-017 SHALL pass LCD_E, LCD_RS, LCD_RW and LCD_DATA through SYNC_STAGES flops before use.
REQ-018 SHALL register synced RS/RW/DATA every cycle synced E = 1; a strobe is synced E 1->0, and uses those registered values.
REQ-019 SHALL ignore strobes with RW = 1: no state change, no flags.
REQ-020 SHALL, on a data strobe (RS = 1), write DATA to buffer[cursor], then step cursor +1 if ID = 1, else -1.
REQ-021 SHALL wrap cursor 31->0 on increment and 0->31 on decrement; 15->16 and 16->15 are ordinary steps.
REQ-022 SHALL decode a command strobe (RS = 0) by its highest set bit:
  0x01 clear: enter CLEAR; cursor = 0, ID = 1.
  0x02-0x03 home: cursor = 0.
  0x04-0x07 entry mode: ID = DATA[1]; DATA[0] ignored.
  0x08-0x0F display control: disp_on = DATA[2].
  0x10-0x7F shift/function/CGRAM: no state effect.
  0x80-0x8F: cursor = DATA[3:0]; 0xC0-0xCF: cursor = 16 + DATA[3:0].
  Any other 0x80+ value: set err, cursor unchanged.
  0x00: no state effect.
REQ-023 SHALL pulse cmd_valid one cycle after every non-ignored command strobe and update cmd_code in that same cycle, including for 0x00 and illegal addresses.
REQ-024 SHALL have two states, IDLE and CLEAR. CLEAR writes 0x20 to index k on its k-th cycle (k = 0..31), then returns to IDLE. busy = 1 for exactly those 32 cycles.
REQ-025 SHALL, for any strobe while busy = 1, drop the strobe and set err, with no cmd_valid.
REQ-026 SHALL register rd_char from rd_addr: one-cycle latency, valid in every state. During CLEAR it returns partially cleared contents.
REQ-027 SHALL give the 32-cycle sequence priority if a new 0x01 arrives in the cycle busy falls; that strobe is accepted normally.

Reset
REQ-028 SHALL, on rst = 1 at a clock edge, set all buffer cells to 0x20; cursor = 0, ID = 1, disp_on = 0, busy = 0, cmd_valid = 0, cmd_code = 0x00, err = 0, rd_char = 0x20, state IDLE, and flush synchronizers and edge history to 0.
REQ-029 SHALL, on reset mid-CLEAR or mid-strobe, abandon the operation entirely; E high across reset release produces no strobe until it rises again.

Structure
REQ-030 SHALL place command codes, CHAR_SPACE (0x20), LINE2_BASE (0x40) and the state enum in shared package lcd_pkg.
REQ-031 SHALL place the synchronizer chain and falling-edge detector in sub-module lcd_edge_sync; all other logic stays in lcd_bus_receiver.

Verification
REQ-032 SHALL cover: reset, then read all 32 indices -> every rd_char = 0x20, cursor = 0, err = 0.
REQ-033 SHALL cover: commands 0x06, 0xC0, then data bytes 'A','B' -> index 16 = 0x41, index 17 = 0x42, cursor = 18, two cmd_valid pulses.
REQ-034 SHALL cover: commands 0x04, 0x80, then data 0x5A -> index 0 = 0x5A, cursor = 31.
REQ-035 SHALL cover: fill buffer, send 0x01, then a data strobe 10 cycles later -> busy high 32 cycles, strobe dropped, err = 1, all cells 0x20.
REQ-036 SHALL cover: command 0x95 -> err = 1, cursor unchanged, cmd_valid pulses with cmd_code = 0x95.
REQ-037 SHALL cover: RW = 1 strobe with RS = 1, data 0x33 -> no buffer or cursor change, no cmd_valid.
